// File: rtl/seq_serializer_if.sv
// Word-level valid/ready handshake feeding seq_serializer.
// The upstream producer is the master; the serializer is the slave.
interface seq_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage for the 101 detectors: WIDTH-bit words out MSB-first, IDLE_BIT between frames.
// Define SEQ_SERIALIZER_SKID_EN to add a one-word holding register for gapless back-to-back frames.
//
// state | meaning
// IDLE  | no frame on x_out, line held at IDLE_BIT, ready for a word
// SHIFT | frame bits on x_out, MSB first, bit_cnt counts down to the LSB
module seq_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    seq_serializer_if.slave sif,
    output logic            x_out,
    output logic            x_valid,
    output logic            frame_end,
    output logic            busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    bit_cnt;
    logic             accept;
    logic             last_bit;
    logic             reload;

    assign accept   = sif.din_valid && sif.din_ready;
    assign last_bit = (state == SHIFT) && (bit_cnt == '0);

`ifdef SEQ_SERIALIZER_SKID_EN
    logic [WIDTH-1:0] hold;
    logic             hold_full;

    assign reload = last_bit && hold_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if ((state == SHIFT) && accept) begin
            hold      <= sif.din;
            hold_full <= 1'b1;
        end else if (reload) begin
            hold_full <= 1'b0;
        end
    end
`else
    assign reload = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_bit && !reload) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A back-to-back word is taken from hold at the LSB edge, so the next MSB follows with no gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                sreg    <= sif.din;
                bit_cnt <= CNT_LOAD;
            end
        end else if (reload) begin
`ifdef SEQ_SERIALIZER_SKID_EN
            sreg    <= hold;
`endif
            bit_cnt <= CNT_LOAD;
        end else begin
            sreg    <= {sreg[WIDTH-2:0], 1'b0};
            bit_cnt <= last_bit ? '0 : bit_cnt - CW'(1);
        end
    end

    always_comb begin
        x_out     = IDLE_BIT;
        x_valid   = 1'b0;
        frame_end = 1'b0;
        busy      = 1'b0;
`ifdef SEQ_SERIALIZER_SKID_EN
        sif.din_ready = !hold_full;
`else
        sif.din_ready = (state == IDLE);
`endif
        if (state == SHIFT) begin
            x_out     = sreg[WIDTH-1];
            x_valid   = 1'b1;
            frame_end = last_bit;
            busy      = 1'b1;
        end
    end
endmodule
